if_stage: RTL
=============

# if_stage

Instruction-fetch stage for the LEGv8 pipeline. It holds the program counter and issues single-outstanding requests to instruction memory over a req/ack handshake. It presents a registered `{valid, pc, inst}` to the decode stage, whose `inst` input is driven by `if_inst`. The stage absorbs decode stalls with a one-entry hold buffer and redirects on taken branches or flushes.

## Interface
- `RESET_PC`, default 64'd0: PC value loaded at reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: decode cannot accept; the output register must hold.
- `redirect` input 1: taken branch or flush; discard the in-flight instruction and restart at `redirect_pc`.
- `redirect_pc` input `WORD: new PC; must be word-aligned.
- `imem_req` output 1: request valid.
- `imem_addr` output `WORD: request address.
- `imem_ack` input 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` input `INST_SIZE: fetched instruction.
- `if_valid` output 1: `if_inst`/`if_pc` hold a live instruction.
- `if_pc` output `WORD: PC of `if_inst`.
- `if_inst` output `INST_SIZE: instruction to decode.

## Operation
- FSM states: IDLE, FETCH, HOLD, DISCARD. Reset state is IDLE. IDLE always moves to FETCH on the next cycle.
- `imem_req` = 1 in FETCH and DISCARD, otherwise 0. `imem_addr` = `pc` and stays stable while `imem_req` is high.
- `imem_ack` is legal only while `imem_req` = 1. The bench flags an ack in IDLE/HOLD as an error. Ack may arrive in the same cycle as the request.
- "Output free" = `!if_valid || !stall`.
- In FETCH, on ack without redirect:
  - `pc` <= `pc` + 4 (modulo 2^64).
  - If output is free: load `if_inst`=rdata, `if_pc`=pc, `if_valid`=1, stay in FETCH.
  - Otherwise: capture into the hold buffer and go to HOLD.
- In FETCH, no ack, output free: clear `if_valid` (bubble).
- HOLD: no request is issued. When `!stall`, buffer moves to the output register and the state goes to FETCH.
- A redirect has priority over stall and ack in every state:
  - `pc` <= `redirect_pc`.
  - `if_valid` <= 0 and the buffer is cleared.
  - Any ack in that same cycle is dropped.
  - Next state is DISCARD if a request is outstanding without ack this cycle (FETCH or DISCARD, no ack). Otherwise it is FETCH.
- DISCARD: keeps `imem_addr` at the old address until ack. On ack the data is dropped and the state goes to FETCH. A redirect in DISCARD only updates the pending `pc`; `imem_addr` stays on the old outstanding address.
  - Therefore `pc` and `imem_addr` decouple in DISCARD. Hold the outstanding address in its own register.
- `redirect_pc` bits [1:0] are ignored; they are forced to 0.

## Timing
- Reset values: `if_valid`=0, `if_pc`=0, `if_inst`=0, `imem_req`=0, `pc`=RESET_PC, buffer empty.
- Asserting reset mid-transaction abandons it immediately. Memory must tolerate a dropped request.
- Latency: ack in cycle N means `if_inst` is valid in N+1, provided output is free.
- With a zero-wait memory (ack in the same cycle as req), the stage sustains one instruction per cycle.
- From redirect in cycle N, the first request to `redirect_pc` is issued in N+1 (state FETCH) or after the old ack (state DISCARD).
- While `stall` and `if_valid` are both 1, `if_inst`/`if_pc` are held bit-stable.

## Configuration
- Macro `IF_PERF_EN` defined adds two outputs:
  - `perf_fetch_cnt` [31:0]: counts acks loaded to the output or buffer.
  - `perf_bubble_cnt` [31:0]: counts cycles where `!if_valid && !stall`.
  - Both counters reset to 0 and wrap at 2^32.
- Macro undefined: the ports and counters are absent, with no other behavioural change.

## Structure
- `common.vh` carries `WORD`, `INST_SIZE`, the new `PC_STEP` (4) and the FSM state encodings `IF_IDLE`/`IF_FETCH`/`IF_HOLD`/`IF_DISCARD`.
- One sub-module, `pc_reg`: PC register with reset value `RESET_PC`, increment enable, and redirect load.

## Test plan
- Reset release, memory acks in the same cycle with rdata=0x8B020020, 0x8B030041, … → `if_pc` = 0, 4, 8 on consecutive cycles from the second cycle after reset, `if_valid` continuously 1.
- `stall` high for 3 cycles while output is valid and an ack arrives → instruction enters HOLD, `imem_req`=0, output unchanged. On stall release the buffered instruction appears next cycle with the correct `if_pc`, and there is no loss or duplicate.
- Ack delayed 2 cycles, `redirect`=1 with `redirect_pc`=0x100 in the first wait cycle → state DISCARD, `imem_addr` holds the old address, the late rdata is dropped, and the next request is to 0x100.
- `redirect` (`redirect_pc`=0x40) in the same cycle as an ack → ack dropped, `if_valid`=0 next cycle, and the following request is to 0x40.
- `rst_n` pulled low mid-wait → all outputs return to reset values asynchronously, and after release fetch restarts at RESET_PC=0x1000.
- With `IF_PERF_EN`: 10 fetches plus 3 bubble cycles → `perf_fetch_cnt`=10, `perf_bubble_cnt`=3.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared widths, PC step and fetch FSM encodings for the LEGv8 instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned WORD      = 64;
    localparam int unsigned INST_SIZE = 32;

    localparam logic [WORD-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_FETCH,
        IF_HOLD,
        IF_DISCARD
    } if_state_e;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter: reset to RESET_PC, redirect load has priority over the sequential increment.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_en,
    input  logic            load_en,
    input  logic [WORD-1:0] load_pc,
    output logic [WORD-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= load_pc;
        end else if (inc_en) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: single-outstanding imem requests, one-entry hold buffer, redirect.
// Optional performance counters are enabled by defining IF_PERF_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = 64'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD-1:0]      redirect_pc,
    output logic                 imem_req,
    output logic [WORD-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [INST_SIZE-1:0] imem_rdata,
    output logic                 if_valid,
    output logic [WORD-1:0]      if_pc,
    output logic [INST_SIZE-1:0] if_inst
`ifdef IF_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_bubble_cnt
`endif
);

    if_state_e            state;
    logic [WORD-1:0]      pc;
    logic [WORD-1:0]      addr_q;
    logic [WORD-1:0]      buf_pc;
    logic [INST_SIZE-1:0] buf_inst;
    logic                 out_free;
    logic                 fetch_accept;

    assign out_free     = !if_valid || !stall;
    assign fetch_accept = (state == IF_FETCH) && imem_ack && !redirect;

    // The outstanding address lives in addr_q while a discarded request drains.
    assign imem_req  = (state == IF_FETCH) || (state == IF_DISCARD);
    assign imem_addr = (state == IF_DISCARD) ? addr_q : pc;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (fetch_accept),
        .load_en (redirect),
        .load_pc (redirect_pc & ~64'd3),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IF_IDLE;
            addr_q   <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
            buf_pc   <= '0;
            buf_inst <= '0;
        end else if (redirect) begin
            if_valid <= 1'b0;
            if ((state == IF_FETCH) && !imem_ack) begin
                state  <= IF_DISCARD;
                addr_q <= pc;
            end else if ((state == IF_DISCARD) && !imem_ack) begin
                state <= IF_DISCARD;
            end else begin
                state <= IF_FETCH;
            end
        end else begin
            unique case (state)
                IF_IDLE: state <= IF_FETCH;
                IF_FETCH: begin
                    if (imem_ack) begin
                        if (out_free) begin
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                            if_inst  <= imem_rdata;
                        end else begin
                            buf_pc   <= pc;
                            buf_inst <= imem_rdata;
                            state    <= IF_HOLD;
                        end
                    end else if (out_free) begin
                        if_valid <= 1'b0;
                    end
                end
                IF_HOLD: begin
                    if (!stall) begin
                        if_valid <= 1'b1;
                        if_pc    <= buf_pc;
                        if_inst  <= buf_inst;
                        state    <= IF_FETCH;
                    end
                end
                IF_DISCARD: begin
                    if (imem_ack) begin
                        state <= IF_FETCH;
                    end
                end
                default: state <= IF_IDLE;
            endcase
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (fetch_accept) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (!if_valid && !stall) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
